// File: rtl/oram_access_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : oram_access_scheduler
// Description : Rate-enforcing command scheduler between the ORAM frontend
//               and PathORAMBackend. With ORAM_RATE_LIMIT_EN defined, one
//               backend access is issued per programmable interval. A pending
//               frontend command is forwarded; otherwise a dummy Read to an
//               LFSR-chosen leaf is issued. Load data returned for dummy
//               accesses is swallowed. Without ORAM_RATE_LIMIT_EN, commands
//               are forwarded on demand and load data passes straight through.
// Revision    : 1.0 - initial release
// ============================================================================
module oram_access_scheduler #(
    parameter int          ORAMU         = 32,
    parameter int          ORAML         = 10,
    parameter int          FEDWidth      = 64,
    parameter int          BlkChunks     = 8,
    parameter int          IntervalWidth = 16,
    parameter int          TagDepth      = 4,
    parameter logic [31:0] LFSRSeed      = 32'hACE1_0001
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic [IntervalWidth-1:0] Interval,

    input  logic [1:0]               FE_Command,
    input  logic [ORAMU-1:0]         FE_PAddr,
    input  logic [ORAML-1:0]         FE_CurrentLeaf,
    input  logic [ORAML-1:0]         FE_RemappedLeaf,
    input  logic                     FE_CommandValid,
    output logic                     FE_CommandReady,

    input  logic [FEDWidth-1:0]      FE_StoreData,
    input  logic                     FE_StoreValid,
    output logic                     FE_StoreReady,

    output logic [FEDWidth-1:0]      FE_LoadData,
    output logic                     FE_LoadValid,
    input  logic                     FE_LoadReady,

    output logic [1:0]               BE_Command,
    output logic [ORAMU-1:0]         BE_PAddr,
    output logic [ORAML-1:0]         BE_CurrentLeaf,
    output logic [ORAML-1:0]         BE_RemappedLeaf,
    output logic                     BE_CommandValid,
    input  logic                     BE_CommandReady,

    output logic [FEDWidth-1:0]      BE_StoreData,
    output logic                     BE_StoreValid,
    input  logic                     BE_StoreReady,

    input  logic [FEDWidth-1:0]      BE_LoadData,
    input  logic                     BE_LoadValid,
    output logic                     BE_LoadReady,

    output logic [31:0]              DummyCount
);

    localparam logic [1:0] c_CmdRead    = 2'd2;
    localparam logic [1:0] c_CmdReadRmv = 2'd3;
    localparam int         c_ChunkW     = (BlkChunks > 1) ? $clog2(BlkChunks) : 1;
    localparam logic [c_ChunkW-1:0] c_LastChunk = c_ChunkW'(BlkChunks - 1);

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_STORE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_nextState;

    logic [1:0]           r_cmd;
    logic [ORAMU-1:0]     r_paddr;
    logic [ORAML-1:0]     r_curLeaf;
    logic [ORAML-1:0]     r_remLeaf;
    logic                 r_isDummy;
    logic [c_ChunkW-1:0]  r_storeCnt;

    logic                 w_issueFire;
    logic                 w_storeFire;
    logic                 w_storeLast;
    logic                 w_isLoadCmd;
    logic                 w_decide;
    logic                 w_takeReal;

    assign w_issueFire = (r_state == ST_ISSUE) && BE_CommandReady;
    assign w_storeFire = (r_state == ST_STORE) && FE_StoreValid && BE_StoreReady;
    assign w_storeLast = w_storeFire && (r_storeCnt == c_LastChunk);
    assign w_isLoadCmd = (r_cmd == c_CmdRead) || (r_cmd == c_CmdReadRmv);

`ifdef ORAM_RATE_LIMIT_EN
    localparam int                c_TagAW        = $clog2(TagDepth);
    localparam logic [c_TagAW:0]  c_TagFullCount = TagDepth[c_TagAW:0];

    logic [IntervalWidth-1:0] r_timer;
    logic [IntervalWidth-1:0] w_timerMax;
    logic                     w_timerSat;
    logic [31:0]              r_lfsr;
    logic [31:0]              w_lfsrNext;
    logic [31:0]              r_dummyCount;
    logic                     r_tagMem [TagDepth];
    logic [c_TagAW-1:0]       r_tagRd;
    logic [c_TagAW-1:0]       r_tagWr;
    logic [c_TagAW:0]         r_tagCount;
    logic [c_ChunkW-1:0]      r_loadCnt;
    logic                     w_tagEmpty;
    logic                     w_tagFull;
    logic                     w_headDummy;
    logic                     w_tagPush;
    logic                     w_tagPop;
    logic                     w_loadFire;

    // An interval of zero behaves like one: the timer is saturated at zero.
    assign w_timerMax  = (Interval == '0) ? '0 : (Interval - IntervalWidth'(1));
    assign w_timerSat  = (r_timer >= w_timerMax);
    assign w_tagEmpty  = (r_tagCount == '0);
    assign w_tagFull   = (r_tagCount == c_TagFullCount);
    assign w_headDummy = !w_tagEmpty && r_tagMem[r_tagRd];
    // Only decide while a load tag slot is free, so a full FIFO holds WAIT.
    assign w_decide    = (r_state == ST_WAIT) && w_timerSat && !w_tagFull;
    assign w_takeReal  = w_decide && FE_CommandValid;
    // Galois LFSR, x^32 + x^22 + x^2 + x + 1, shifting right.
    assign w_lfsrNext  = r_lfsr[0] ? ((r_lfsr >> 1) ^ 32'h8020_0003) : (r_lfsr >> 1);
    assign w_loadFire  = !w_tagEmpty && BE_LoadValid && BE_LoadReady;
    assign w_tagPop    = w_loadFire && (r_loadCnt == c_LastChunk);
    assign w_tagPush   = w_issueFire && w_isLoadCmd;
    assign DummyCount  = r_dummyCount;

    // Interval timer: counts up while not issuing, clears on every issue handshake.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_timer <= '0;
        end else if (w_issueFire) begin
            r_timer <= '0;
        end else if ((r_state != ST_ISSUE) && !w_timerSat) begin
            r_timer <= r_timer + IntervalWidth'(1);
        end
    end

    // Dummy leaf generator and dummy counter advance once per dummy handshake.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_lfsr       <= LFSRSeed;
            r_dummyCount <= '0;
        end else if (w_issueFire && r_isDummy) begin
            r_lfsr       <= w_lfsrNext;
            r_dummyCount <= r_dummyCount + 32'd1;
        end
    end

    // Tag storage: one bit per outstanding load, set when the access was a dummy.
    always_ff @(posedge Clock) begin
        if (w_tagPush) begin
            r_tagMem[r_tagWr] <= r_isDummy;
        end
    end

    // Tag FIFO pointers and occupancy; push and pop may coincide.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_tagRd    <= '0;
            r_tagWr    <= '0;
            r_tagCount <= '0;
        end else begin
            if (w_tagPush) begin
                r_tagWr <= r_tagWr + 1'b1;
            end
            if (w_tagPop) begin
                r_tagRd <= r_tagRd + 1'b1;
            end
            case ({w_tagPush, w_tagPop})
                2'b10:   r_tagCount <= r_tagCount + 1'b1;
                2'b01:   r_tagCount <= r_tagCount - 1'b1;
                default: r_tagCount <= r_tagCount;
            endcase
        end
    end

    // Load chunk counter: retires the head tag after a full block of chunks.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_loadCnt <= '0;
        end else if (w_loadFire) begin
            r_loadCnt <= (r_loadCnt == c_LastChunk) ? '0 : (r_loadCnt + 1'b1);
        end
    end

    // Load routing: real blocks go to the frontend, dummy blocks are drained here.
    always_comb begin
        FE_LoadValid = 1'b0;
        FE_LoadData  = '0;
        BE_LoadReady = 1'b0;
        if (!w_tagEmpty) begin
            if (w_headDummy) begin
                BE_LoadReady = 1'b1;
            end else begin
                FE_LoadValid = BE_LoadValid;
                FE_LoadData  = BE_LoadData;
                BE_LoadReady = FE_LoadReady;
            end
        end
    end
`else
    logic w_unusedRateCfg;

    assign w_unusedRateCfg = ^{Interval, LFSRSeed, 32'(TagDepth)};
    assign w_decide        = (r_state == ST_WAIT) && FE_CommandValid;
    assign w_takeReal      = w_decide;
    assign DummyCount      = '0;

    // Load routing: every returned block belongs to the frontend.
    always_comb begin
        FE_LoadValid = BE_LoadValid;
        FE_LoadData  = BE_LoadData;
        BE_LoadReady = FE_LoadReady;
    end
`endif

    // Command latch: captured at the issue decision, held through ISSUE.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_cmd     <= '0;
            r_paddr   <= '0;
            r_curLeaf <= '0;
            r_remLeaf <= '0;
            r_isDummy <= 1'b0;
        end else if (w_decide) begin
            if (w_takeReal) begin
                r_cmd     <= FE_Command;
                r_paddr   <= FE_PAddr;
                r_curLeaf <= FE_CurrentLeaf;
                r_remLeaf <= FE_RemappedLeaf;
                r_isDummy <= 1'b0;
            end
`ifdef ORAM_RATE_LIMIT_EN
            else begin
                r_cmd     <= c_CmdRead;
                r_paddr   <= '1;
                r_curLeaf <= r_lfsr[ORAML-1:0];
                r_remLeaf <= r_lfsr[2*ORAML-1:ORAML];
                r_isDummy <= 1'b1;
            end
`endif
        end
    end

    // Store chunk counter: counts handshakes of the block being written.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_storeCnt <= '0;
        end else if (w_storeFire) begin
            r_storeCnt <= w_storeLast ? '0 : (r_storeCnt + 1'b1);
        end
    end

    // FSM state register.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= ST_WAIT;
        end else begin
            r_state <= w_nextState;
        end
    end

    // FSM next state plus backend command and store channel outputs.
    always_comb begin
        w_nextState     = r_state;
        BE_Command      = r_cmd;
        BE_PAddr        = r_paddr;
        BE_CurrentLeaf  = r_curLeaf;
        BE_RemappedLeaf = r_remLeaf;
        BE_CommandValid = 1'b0;
        FE_CommandReady = 1'b0;
        BE_StoreData    = '0;
        BE_StoreValid   = 1'b0;
        FE_StoreReady   = 1'b0;
        case (r_state)
            ST_WAIT: begin
                if (w_decide) begin
                    w_nextState = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                BE_CommandValid = 1'b1;
                FE_CommandReady = BE_CommandReady && !r_isDummy;
                if (BE_CommandReady) begin
                    w_nextState = w_isLoadCmd ? ST_WAIT : ST_STORE;
                end
            end
            ST_STORE: begin
                BE_StoreData  = FE_StoreData;
                BE_StoreValid = FE_StoreValid;
                FE_StoreReady = BE_StoreReady;
                if (w_storeLast) begin
                    w_nextState = ST_WAIT;
                end
            end
            default: begin
                w_nextState = ST_WAIT;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: doc/oram_access_scheduler.md
# oram_access_scheduler

Rate-enforcing command scheduler between the ORAM frontend and `PathORAMBackend`. It issues exactly one backend access per programmable interval. When a frontend command is pending it is forwarded; otherwise a dummy Read to a random leaf is issued, so the backend access pattern is independent of frontend demand. It also forwards store data and routes returned load data, discarding the blocks returned by dummy accesses.

## Interface
Parameters:
- `ORAMU`, 32, physical address width
- `ORAML`, 10, leaf width
- `FEDWidth`, 64, frontend data chunk width
- `BlkChunks`, 8, FEDWidth chunks per block
- `IntervalWidth`, 16, width of `Interval`
- `TagDepth`, 4, outstanding load-tag FIFO depth (power of 2)
- `LFSRSeed`, 32'hACE1_0001, dummy-leaf LFSR reset value (nonzero)

Ports:
- `Clock` in 1: clock
- `Reset` in 1: synchronous, active-high
- `Interval` in IntervalWidth: minimum cycles between issue handshakes; 0 is treated as 1
- `FE_Command` in 2, `FE_PAddr` in ORAMU, `FE_CurrentLeaf` in ORAML, `FE_RemappedLeaf` in ORAML, `FE_CommandValid` in 1, `FE_CommandReady` out 1: frontend command
- `FE_StoreData` in FEDWidth, `FE_StoreValid` in 1, `FE_StoreReady` out 1
- `FE_LoadData` out FEDWidth, `FE_LoadValid` out 1, `FE_LoadReady` in 1
- `BE_Command` out 2, `BE_PAddr` out ORAMU, `BE_CurrentLeaf` out ORAML, `BE_RemappedLeaf` out ORAML, `BE_CommandValid` out 1, `BE_CommandReady` in 1
- `BE_StoreData` out FEDWidth, `BE_StoreValid` out 1, `BE_StoreReady` in 1
- `BE_LoadData` in FEDWidth, `BE_LoadValid` in 1, `BE_LoadReady` out 1
- `DummyCount` out 32: dummy accesses issued since reset, wraps

Command encoding: Update=0, Append=1, Read=2, ReadRmv=3.

## Operation
- FSM states: WAIT, ISSUE, STORE.
- **WAIT:** the timer increments each cycle, saturating at Interval−1.
  - At saturation, if the tag FIFO is not full, go to ISSUE.
  - At issue-decision time, if `FE_CommandValid`=1, latch the frontend command (real). Otherwise latch the dummy: Read, PAddr all-ones, CurrentLeaf = LFSR[ORAML-1:0], RemappedLeaf = LFSR[2·ORAML-1:ORAML].
  - Frontend valid and timer expiry in the same cycle: real wins.
- **ISSUE:** `BE_CommandValid`=1 with the latched fields until `BE_CommandReady`.
  - On handshake: the timer clears to 0.
  - Real command: `FE_CommandReady` pulses for that cycle.
  - Dummy command: `DummyCount` increments and the LFSR advances (32-bit Galois, taps 32,22,2,1).
  - Read or ReadRmv: push a tag (1=dummy) into the tag FIFO.
  - Next state: Append or Update go to STORE; all others go to WAIT.
- **STORE:** `BE_StoreData`/`BE_StoreValid` come combinationally from the FE store inputs, and `FE_StoreReady` = `BE_StoreReady`. After BlkChunks handshakes go to WAIT. The timer runs during STORE.
- **Load routing:**
  - Head tag real: `FE_LoadData`/`FE_LoadValid` pass through and `BE_LoadReady` = `FE_LoadReady`.
  - Head tag dummy: `BE_LoadReady`=1 and `FE_LoadValid`=0.
  - A chunk counter pops the tag after BlkChunks load handshakes.
  - Empty FIFO: `BE_LoadReady`=0.
- `FE_StoreReady`=0 outside STORE. `FE_CommandReady`=0 except at the real issue handshake.

## Timing
- Reset values:
  - State WAIT, timer 0, LFSR=LFSRSeed, tag FIFO empty, chunk counters 0, `DummyCount` 0.
  - All valid/ready outputs 0; `BE_*` fields 0.
- Reset mid-operation (any state) discards the latched command, tags and partial block. The environment resets the backend concurrently.
- Issue spacing: with Interval=N and zero-stall backend, consecutive `BE_CommandValid&BE_CommandReady` handshakes are exactly N+1 cycles apart (N-1 WAIT saturation, 1 decision, 1 ISSUE). Backend stalls lengthen the gap and never shorten it.
- Tag FIFO full at expiry: remain in WAIT with the timer held saturated; no frontend command is accepted.
- Simultaneous tag push and pop are legal at full or empty.

## Configuration
- `ORAM_RATE_LIMIT_EN` defined: behaviour as above.
- Undefined: the timer and dummy generation are removed.
  - WAIT goes to ISSUE only when `FE_CommandValid`=1, at the earliest one cycle after the previous handshake.
  - `DummyCount` is tied to 0.
  - Load routing passes everything through; all tags are real.

## Test plan
- **Idle, dummies only:** Interval=10, no frontend traffic, 1000 cycles → 90 dummy Reads (±1) with PAddr=0xFFFFFFFF. `DummyCount`=`BE` handshake count; `FE_LoadValid` never 1 while 8 chunks per dummy drain.
- **Append then Read:** Append paddr 5 with data 0..7, then Read paddr 5 leaf 5→105 → `BE_StoreData` 0..7 in order; `FE_LoadData` receives exactly the backend's 8 chunks, none dropped.
- **Priority:** `FE_CommandValid` asserted in the same cycle the timer saturates → real command issued, no dummy, `DummyCount` unchanged.
- **Backpressure:** `FE_LoadReady`=0 with 4 reads outstanding and TagDepth=4 → no 5th issue and no dummy; release → issue resumes; spacing is never below Interval+1.
- **Reset mid-STORE:** Update after 3 of 8 chunks, Reset for 1 cycle → all outputs return to reset values; the next handshake is a dummy at Interval+1 cycles.
- **Macro undefined:** 3 back-to-back Reads → handshakes 2 cycles apart, `DummyCount`=0.
